// File: rtl/ps2_ascii_fifo_if.sv
// Scan-code input, ASCII read port and status flags of the PS/2-to-ASCII buffer.
// The master drives bytes and reads; the slave is the translator/FIFO.
interface ps2_ascii_fifo_if #(parameter int DEPTH = 8);
  logic [7:0]               ps2_key_data;
  logic                     ps2_key_pressed;
  logic                     ascii_rd;
  logic [7:0]               ascii_data;
  logic                     ascii_valid;
  logic                     fifo_full;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;
  logic                     shift_active;

  modport master (
    output ps2_key_data, ps2_key_pressed, ascii_rd,
    input  ascii_data, ascii_valid, fifo_full, fifo_count, overflow, shift_active
  );

  modport slave (
    input  ps2_key_data, ps2_key_pressed, ascii_rd,
    output ascii_data, ascii_valid, fifo_full, fifo_count, overflow, shift_active
  );
endinterface

// File: rtl/ps2_ascii_fifo.sv
// Set-2 scan-code to ASCII translator feeding a first-word-fall-through FIFO.
//   state       | meaning
//   S_IDLE      | waiting for a make code or a prefix
//   S_BREAK     | F0 seen; next byte is a released key
//   S_EXT       | E0 seen; extended key, discarded
//   S_EXT_BREAK | E0 F0 seen; released extended key, discarded
module ps2_ascii_fifo #(
  parameter int DEPTH = 8
) (
  input logic            inclock,
  input logic            resetn,
  ps2_ascii_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

  state_t          state, state_nxt;
  logic            lshift, rshift, lshift_nxt, rshift_nxt;
  logic            push_req, do_push, do_pop, full;
  logic            map_hit;
  logic [7:0]      map_chr, chr;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  always_comb begin
    map_hit = 1'b1;
    map_chr = 8'h00;
    case (bus.ps2_key_data)
      8'h1C: map_chr = 8'h61;  8'h32: map_chr = 8'h62;  8'h21: map_chr = 8'h63;
      8'h23: map_chr = 8'h64;  8'h24: map_chr = 8'h65;  8'h2B: map_chr = 8'h66;
      8'h34: map_chr = 8'h67;  8'h33: map_chr = 8'h68;  8'h43: map_chr = 8'h69;
      8'h3B: map_chr = 8'h6A;  8'h42: map_chr = 8'h6B;  8'h4B: map_chr = 8'h6C;
      8'h3A: map_chr = 8'h6D;  8'h31: map_chr = 8'h6E;  8'h44: map_chr = 8'h6F;
      8'h4D: map_chr = 8'h70;  8'h15: map_chr = 8'h71;  8'h2D: map_chr = 8'h72;
      8'h1B: map_chr = 8'h73;  8'h2C: map_chr = 8'h74;  8'h3C: map_chr = 8'h75;
      8'h2A: map_chr = 8'h76;  8'h1D: map_chr = 8'h77;  8'h22: map_chr = 8'h78;
      8'h35: map_chr = 8'h79;  8'h1A: map_chr = 8'h7A;
      8'h45: map_chr = 8'h30;  8'h16: map_chr = 8'h31;  8'h1E: map_chr = 8'h32;
      8'h26: map_chr = 8'h33;  8'h25: map_chr = 8'h34;  8'h2E: map_chr = 8'h35;
      8'h36: map_chr = 8'h36;  8'h3D: map_chr = 8'h37;  8'h3E: map_chr = 8'h38;
      8'h46: map_chr = 8'h39;
      8'h29: map_chr = 8'h20;  8'h5A: map_chr = 8'h0D;  8'h66: map_chr = 8'h08;
      default: map_hit = 1'b0;
    endcase
  end

  // Only letters fold to uppercase; shift state is the registered value, before this byte.
  assign chr = ((lshift | rshift) && map_chr >= 8'h61 && map_chr <= 8'h7A) ?
               map_chr - 8'h20 : map_chr;

  always_comb begin
    state_nxt  = state;
    lshift_nxt = lshift;
    rshift_nxt = rshift;
    push_req   = 1'b0;
    if (bus.ps2_key_pressed) begin
      case (state)
        S_IDLE: begin
          if (bus.ps2_key_data == 8'hF0)      state_nxt = S_BREAK;
          else if (bus.ps2_key_data == 8'hE0) state_nxt = S_EXT;
          else if (bus.ps2_key_data == 8'h12) lshift_nxt = 1'b1;
          else if (bus.ps2_key_data == 8'h59) rshift_nxt = 1'b1;
          else                                push_req = map_hit;
        end
        S_BREAK: begin
          if (bus.ps2_key_data == 8'h12)      lshift_nxt = 1'b0;
          else if (bus.ps2_key_data == 8'h59) rshift_nxt = 1'b0;
          state_nxt = S_IDLE;
        end
        S_EXT:   state_nxt = (bus.ps2_key_data == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = bus.ascii_rd && (count != '0);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge inclock) begin
    if (!resetn) begin
      state    <= S_IDLE;
      lshift   <= 1'b0;
      rshift   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bus.overflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      lshift <= lshift_nxt;
      rshift <= rshift_nxt;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && !do_push) bus.overflow <= 1'b1;
    end
  end

  always_ff @(posedge inclock) begin
    if (do_push) mem[wr_ptr] <= chr;
  end

  assign bus.ascii_valid  = (count != '0);
  assign bus.ascii_data   = (count != '0) ? mem[rd_ptr] : 8'h00;
  assign bus.fifo_full    = full;
  assign bus.fifo_count   = count;
  assign bus.shift_active = lshift | rshift;
endmodule

// File: doc/ps2_ascii_fifo.md
Name: ps2_ascii_fifo

Overview:
- Sits directly downstream of the PS/2 interface stage.
- Consumes its received scan-code bytes (set 2) and their one-cycle valid strobe.
- Tracks break (F0) and extended (E0) prefixes and shift state, and translates key presses to ASCII.
- Buffers the ASCII characters in a FIFO that the processor drains with a read-pop handshake.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2.

Ports:
inclock  input  1  system clock; all logic on the rising edge.
resetn  input  1  synchronous, active-low reset.
ps2_key_data  input  8  scan-code byte from the PS/2 interface.
ps2_key_pressed  input  1  one-cycle strobe; ps2_key_data is valid this cycle.
ascii_rd  input  1  pop the head entry; ignored when the FIFO is empty.
ascii_data  output  8  ASCII at the FIFO head; 8'h00 when empty.
ascii_valid  output  1  FIFO non-empty.
fifo_full  output  1  count equals DEPTH.
fifo_count  output  log2(DEPTH)+1  number of entries held.
overflow  output  1  sticky; set when a character is dropped because the FIFO is full.
shift_active  output  1  a shift key is currently held.

Behaviour:
- Reset (resetn=0 at an edge): FSM to IDLE, shift flags cleared, FIFO emptied (pointers and count 0), overflow=0. Resulting outputs: ascii_data=00, ascii_valid=0, fifo_full=0, fifo_count=0, shift_active=0. Reset wins over every other event in the same cycle.
- Bytes are processed only on cycles where ps2_key_pressed=1; otherwise the FSM and shift flags hold.
- FSM states: IDLE, BREAK, EXT, EXT_BREAK.
  - IDLE: F0 -> BREAK; E0 -> EXT; 12 sets lshift; 59 sets rshift; a mapped make code pushes its ASCII; an unmapped code is dropped (this includes FA and AA). Stay in IDLE.
  - BREAK: 12 clears lshift; 59 clears rshift; any other byte is ignored, including E0 and F0. Always -> IDLE.
  - EXT: F0 -> EXT_BREAK; any other byte is discarded -> IDLE.
  - EXT_BREAK: any byte is discarded -> IDLE.
- shift_active = lshift | rshift.
- Shift state is evaluated before the current byte updates it.
- Map, lowercase; shift_active=1 gives uppercase (subtract 20h) for letters only:
  - a1C b32 c21 d23 e24 f2B g34 h33 i43 j3B k42 l4B m3A
  - n31 o44 p4D q15 r2D s1B t2C u3C v2A w1D x22 y35 z1A
  - 0:45 1:16 2:1E 3:26 4:25 5:2E 6:36 7:3D 8:3E 9:46
  - space 29->20, enter 5A->0D, backspace 66->08
  - Digits and control codes are unaffected by shift.
- Typematic repeats: every make byte pushes a character; there is no repeat suppression.
- Latency: a push occurs at the edge that samples the strobe. ascii_valid and ascii_data reflect the new entry in the following cycle.
- FIFO is first-word-fall-through. ascii_rd=1 with ascii_valid=1 pops at the edge, and the next entry appears the following cycle.
- Simultaneous push and pop:
  - Non-empty FIFO: both occur and the count is unchanged.
  - When full: both succeed; overflow is not set.
  - When empty: the push succeeds and the pop is ignored.
- Push when full without a pop: the character is dropped, overflow is set to 1 and stays set until reset, and FIFO contents are unchanged.
- Pointers wrap modulo DEPTH.
- fifo_count never exceeds DEPTH and never underflows.

Test Plan:
- Reset, then bytes 1C, F0, 1C -> exactly one entry 61 ('a'); ascii_valid rises 1 cycle after the 1C strobe; fifo_count=1; FSM returns to IDLE.
- Bytes 12, 1C, 16, F0, 12, 1C -> entries 41, 31, 61; shift_active=1 from the cycle after 12 until the cycle after the second 12.
- Bytes E0, 75, E0, F0, 75, 29 -> only entry 20; FA and AA sent from IDLE push nothing.
- With DEPTH=8: push 9 mapped keys with no reads -> fifo_full=1, count=8, overflow=1, and the 9th key is absent. Pop 8 times -> 8 original characters in order, then ascii_valid=0 and ascii_data=00.
- With the FIFO full: ascii_rd=1 in the same cycle as a new key strobe -> count stays 8, overflow stays 0, and the new key appears last after draining. ascii_rd on an empty FIFO -> no change.
- Send F0, assert resetn=0 for one edge, then 1C -> entry 61 pushed (the break state was cleared by reset); a pending shift is cleared, so the result is lowercase.
